// File: rtl/lts_capture_ctrl_if.sv
// AXI-Stream bundle for the LTS capture path: 32-bit {I[15:0],Q[15:0]} data with tlast.
interface lts_capture_ctrl_if;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [31:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/lts_capture_ctrl.sv
// Capture sequencer between lts_extractor and the CSI DMA stream.
// Optional LTS_CAPTURE_HEADER_EN prefixes each frame with {16'hC510, capture index}.
module lts_capture_ctrl #(
    parameter int unsigned LTS_LEN        = 128,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               arm_in,
    input  logic               abort_in,
    input  logic [CNT_W-1:0]   num_captures_in,
    input  logic [CNT_W-1:0]   holdoff_in,
    output logic               extractor_rst_out,
    lts_capture_ctrl_if.slave  lts_axis,
    lts_capture_ctrl_if.master m_axis,
    output logic               busy_out,
    output logic               done_out,
    output logic [CNT_W-1:0]   capture_cnt_out,
    output logic [2:0]         error_out
);

    localparam int unsigned      TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_L  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [15:0]      LEN_L = 16'(LTS_LEN);

    typedef enum logic [2:0] {
        IDLE,
        HOLDOFF,
        ARMED,
`ifdef LTS_CAPTURE_HEADER_EN
        HEADER,
`endif
        STREAM,
        DRAIN,
        FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cfg_num_q, cfg_num_d;
    logic [CNT_W-1:0] cfg_hold_q, cfg_hold_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [15:0]      beat_cnt_q, beat_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       err_q, err_d;
    logic             mv_q, mv_d;
    logic             ml_q, ml_d;
    logic [31:0]      md_q, md_d;
    logic             done_q, done_d;

    logic             slot_free;
    logic             timed_out;
    logic             in_ready;
    logic             accept;
    logic             frame_end;
    logic [15:0]      beat_next;

    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    assign slot_free = !mv_q || m_axis.tready;
    assign timed_out = (to_cnt_q == TO_L);
    assign accept    = lts_axis.tvalid && in_ready;
    assign beat_next = (state_q == STREAM) ? beat_cnt_q + 16'd1 : 16'd1;

    // With the header enabled, ARMED holds the first sample upstream until the header is queued.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
`ifndef LTS_CAPTURE_HEADER_EN
            ARMED:   in_ready = slot_free;
`endif
            STREAM:  in_ready = slot_free && !timed_out;
            DRAIN:   in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cfg_num_d  = cfg_num_q;
        cfg_hold_d = cfg_hold_q;
        hold_cnt_d = hold_cnt_q;
        beat_cnt_d = beat_cnt_q;
        to_cnt_d   = to_cnt_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        mv_d       = mv_q && !m_axis.tready;
        ml_d       = ml_q;
        md_d       = md_q;
        done_d     = 1'b0;
        frame_end  = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm_in) begin
                    cfg_num_d  = num_captures_in;
                    cfg_hold_d = holdoff_in;
                    hold_cnt_d = at_least_one(holdoff_in);
                    cnt_d      = '0;
                    err_d      = '0;
                    state_d    = HOLDOFF;
                end
            end
            HOLDOFF: begin
                beat_cnt_d = '0;
                to_cnt_d   = '0;
                if (hold_cnt_q <= CNT_W'(1)) state_d = ARMED;
                else                         hold_cnt_d = hold_cnt_q - CNT_W'(1);
            end
            ARMED: begin
`ifdef LTS_CAPTURE_HEADER_EN
                if (lts_axis.tvalid) state_d = HEADER;
`endif
            end
`ifdef LTS_CAPTURE_HEADER_EN
            HEADER: begin
                if (slot_free) begin
                    mv_d    = 1'b1;
                    md_d    = {16'hC510, 16'(cnt_q)};
                    ml_d    = 1'b0;
                    state_d = STREAM;
                end
            end
`endif
            STREAM: begin
                if (timed_out) begin
                    if (slot_free) begin
                        mv_d      = 1'b1;
                        md_d      = '0;
                        ml_d      = 1'b1;
                        err_d[2]  = 1'b1;
                        frame_end = 1'b1;
                    end
                end else if (!accept) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            DRAIN: begin
                if (accept && lts_axis.tlast) frame_end = 1'b1;
            end
            FLUSH: begin
                if (!mv_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Sample path shared by ARMED and STREAM: forward, count and police frame length.
        if (accept && state_q != DRAIN) begin
            beat_cnt_d = beat_next;
            to_cnt_d   = '0;
            mv_d       = 1'b1;
            md_d       = lts_axis.tdata;
            ml_d       = 1'b0;
            state_d    = STREAM;
            if (beat_next == LEN_L) begin
                ml_d = 1'b1;
                if (!lts_axis.tlast) begin
                    err_d[1] = 1'b1;
                    state_d  = DRAIN;
                end else begin
                    frame_end = 1'b1;
                end
            end else if (lts_axis.tlast) begin
                ml_d      = 1'b1;
                err_d[0]  = 1'b1;
                frame_end = 1'b1;
            end
        end

        if (frame_end) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            if (cfg_num_q != '0 && cnt_d == cfg_num_q) begin
                state_d = FLUSH;
            end else begin
                state_d    = HOLDOFF;
                hold_cnt_d = at_least_one(cfg_hold_q);
            end
        end

        if (abort_in) begin
            state_d = IDLE;
            mv_d    = 1'b0;
            done_d  = 1'b0;
            cnt_d   = cnt_q;
            err_d   = err_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            cfg_num_q  <= '0;
            cfg_hold_q <= '0;
            hold_cnt_q <= '0;
            beat_cnt_q <= '0;
            to_cnt_q   <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            mv_q       <= 1'b0;
            ml_q       <= 1'b0;
            md_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_num_q  <= cfg_num_d;
            cfg_hold_q <= cfg_hold_d;
            hold_cnt_q <= hold_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            to_cnt_q   <= to_cnt_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            mv_q       <= mv_d;
            ml_q       <= ml_d;
            md_q       <= md_d;
            done_q     <= done_d;
        end
    end

    assign extractor_rst_out = (state_q == IDLE) || (state_q == HOLDOFF) || (state_q == FLUSH);
    assign busy_out          = (state_q != IDLE);
    assign done_out          = done_q;
    assign capture_cnt_out   = cnt_q;
    assign error_out         = err_q;
    assign lts_axis.tready   = in_ready;
    assign m_axis.tvalid     = mv_q;
    assign m_axis.tlast      = ml_q;
    assign m_axis.tdata      = md_q;

endmodule

// File: tb/tb_lts_capture_ctrl.sv
// Randomized self-checking bench for lts_capture_ctrl against a frame-level reference model.
module tb_lts_capture_ctrl;
    localparam int unsigned LTS_LEN        = 128;
    localparam int unsigned TIMEOUT_CYCLES = 4096;
    localparam int unsigned CNT_W          = 16;
`ifdef LTS_CAPTURE_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic             clk_in = 1'b0;
    logic             rst_n_in = 1'b0;
    logic             arm_in = 1'b0;
    logic             abort_in = 1'b0;
    logic [CNT_W-1:0] num_captures_in = '0;
    logic [CNT_W-1:0] holdoff_in = '0;
    logic             extractor_rst_out, busy_out, done_out;
    logic [CNT_W-1:0] capture_cnt_out;
    logic [2:0]       error_out;

    lts_capture_ctrl_if lts_axis ();
    lts_capture_ctrl_if m_axis ();

    lts_capture_ctrl #(
        .LTS_LEN(LTS_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .arm_in(arm_in),
        .abort_in(abort_in),
        .num_captures_in(num_captures_in),
        .holdoff_in(holdoff_in),
        .extractor_rst_out(extractor_rst_out),
        .lts_axis(lts_axis),
        .m_axis(m_axis),
        .busy_out(busy_out),
        .done_out(done_out),
        .capture_cnt_out(capture_cnt_out),
        .error_out(error_out)
    );

    always #5 clk_in = ~clk_in;

    int          checks = 0;
    int          failures = 0;
    logic [32:0] exp_q[$];
    int          out_beats = 0;
    int          out_lasts = 0;
    int          done_cnt = 0;
    int          exp_hold = 1;
    int unsigned cnt_m = 0;
    logic [2:0]  err_m = '0;
    bit          ready_rand = 1'b0;
    bit          mon_en = 1'b0;
    bit          first_pend = 1'b0;
    logic [31:0] first_word = '0;
    logic [31:0] first_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    // Downstream readiness: always ready or a 50% coin per cycle.
    initial begin
        m_axis.tready = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            m_axis.tready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: output order, AXIS stability, done pulse and hold-off length.
    initial begin
        logic [32:0] e;
        logic        prev_busy, prev_abort, prev_stall, prev_last;
        logic [31:0] prev_data;
        int          rst_run;
        prev_busy = 1'b0; prev_abort = 1'b0; prev_stall = 1'b0; prev_last = 1'b0;
        prev_data = '0; rst_run = 0;
        forever begin
            @(negedge clk_in);
            if (mon_en) begin
                if (prev_abort) exp_q.delete();
                if (prev_stall && !prev_abort) begin
                    chk("stall_valid", 32'(m_axis.tvalid), 32'd1);
                    chk("stall_data", m_axis.tdata, prev_data);
                    chk("stall_last", 32'(m_axis.tlast), 32'(prev_last));
                end
                if (m_axis.tvalid && m_axis.tready) begin
                    out_beats++;
                    if (m_axis.tlast) out_lasts++;
                    if (first_pend) begin
                        first_word = m_axis.tdata;
                        first_pend = 1'b0;
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL out_extra: actual=0x%0h required=no beat", m_axis.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", m_axis.tdata, e[31:0]);
                        chk("out_last", 32'(m_axis.tlast), 32'(e[32]));
                    end
                end
                chk("done", 32'(done_out), 32'(prev_busy && !busy_out && !prev_abort));
                if (done_out) done_cnt++;
                if (busy_out && extractor_rst_out) begin
                    rst_run++;
                end else begin
                    if (busy_out && rst_run > 0) chk("holdoff_len", rst_run, exp_hold);
                    rst_run = 0;
                end
                if (extractor_rst_out) chk("tready_in_rst", 32'(lts_axis.tready), 32'd0);
            end
            prev_busy  = busy_out;
            prev_abort = abort_in;
            prev_stall = m_axis.tvalid && !m_axis.tready;
            prev_data  = m_axis.tdata;
            prev_last  = m_axis.tlast;
        end
    end

    task automatic arm(input int num, input int hold);
        arm_in = 1'b1;
        num_captures_in = CNT_W'(num);
        holdoff_in = CNT_W'(hold);
        @(posedge clk_in);
        #1;
        arm_in = 1'b0;
        num_captures_in = CNT_W'($urandom);
        holdoff_in = CNT_W'($urandom);
        exp_hold = (hold == 0) ? 1 : hold;
        cnt_m = 0;
        err_m = '0;
        first_pend = 1'b1;
        chk("busy_after_arm", 32'(busy_out), 32'd1);
        chk("cnt_after_arm", 32'(capture_cnt_out), 32'd0);
        chk("err_after_arm", 32'(error_out), 32'd0);
    endtask

    // stop_at>0 sends only that many beats without tlast; stall then expects the timeout
    // filler, otherwise the frame is left hanging for an abort.
    task automatic send_frame(input int len, input int stop_at, input bit stall);
        int          n;
        int          w;
        logic [31:0] d;
        logic        last_in;
        n = (stop_at > 0) ? stop_at : len;
        w = 0;
        while (extractor_rst_out !== 1'b0 && w < 1000) begin
            @(posedge clk_in); #1; w++;
        end
        if (extractor_rst_out !== 1'b0) begin
            bound_fail("wait_armed");
            return;
        end
        if (HDR != 0) exp_q.push_back({1'b0, 16'hC510, 16'(cnt_m)});
        for (int i = 1; i <= n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_in); #1;
            end
            d = $urandom;
            if (i == 1) first_data = d;
            last_in = (stop_at == 0) && (i == len);
            lts_axis.tvalid = 1'b1;
            lts_axis.tdata  = d;
            lts_axis.tlast  = last_in;
            w = 0;
            forever begin
                @(negedge clk_in);
                if (lts_axis.tready || w >= 5000) break;
                w++;
            end
            @(posedge clk_in); #1;
            lts_axis.tvalid = 1'b0;
            lts_axis.tlast  = 1'b0;
            if (w >= 5000) begin
                bound_fail("wait_in_ready");
                return;
            end
            if (i <= int'(LTS_LEN)) exp_q.push_back({last_in || (i == int'(LTS_LEN)), d});
        end
        if (stop_at > 0 && !stall) return;
        if (stop_at > 0) begin
            exp_q.push_back({1'b1, 32'h0});
            err_m[2] = 1'b1;
        end else if (len < int'(LTS_LEN)) begin
            err_m[0] = 1'b1;
        end else if (len > int'(LTS_LEN)) begin
            err_m[1] = 1'b1;
        end
        cnt_m++;
        w = 0;
        while (extractor_rst_out !== 1'b1 && w < int'(TIMEOUT_CYCLES) + 1000) begin
            @(posedge clk_in); #1; w++;
        end
        if (extractor_rst_out !== 1'b1) bound_fail("wait_frame_end");
        chk("capture_cnt", 32'(capture_cnt_out), cnt_m);
        chk("error", 32'(error_out), 32'(err_m));
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy_out !== 1'b0 && w < 2000) begin
            @(posedge clk_in); #1; w++;
        end
        if (busy_out !== 1'b0) bound_fail("wait_idle");
        @(posedge clk_in); #1;
        chk("queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int b0, l0, d0, num, len, r;
        lts_axis.tvalid = 1'b0;
        lts_axis.tlast  = 1'b0;
        lts_axis.tdata  = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_extractor", 32'(extractor_rst_out), 32'd1);
        chk("rst_in_ready", 32'(lts_axis.tready), 32'd0);
        chk("rst_m_valid", 32'(m_axis.tvalid), 32'd0);
        chk("rst_m_last", 32'(m_axis.tlast), 32'd0);
        chk("rst_m_data", m_axis.tdata, 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_cnt", 32'(capture_cnt_out), 32'd0);
        chk("rst_err", 32'(error_out), 32'd0);
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        mon_en = 1'b1;

        // Two clean frames, hold-off 10, no backpressure
        b0 = out_beats; l0 = out_lasts; d0 = done_cnt;
        arm(2, 10);
        send_frame(128, 0, 1'b0);
        send_frame(128, 0, 1'b0);
        wait_idle();
        chk("A_beats", out_beats - b0, 256 + 2 * HDR);
        chk("A_lasts", out_lasts - l0, 2);
        chk("A_done", done_cnt - d0, 1);
        chk("A_err", 32'(error_out), 32'd0);
        chk("A_cnt", 32'(capture_cnt_out), 32'd2);

        // Short frame under random backpressure
        ready_rand = 1'b1;
        b0 = out_beats;
        arm(1, 3);
        send_frame(40, 0, 1'b0);
        wait_idle();
        chk("B_beats", out_beats - b0, 40 + HDR);
        chk("B_err", 32'(error_out), 32'b001);
        chk("B_cnt", 32'(capture_cnt_out), 32'd1);

        // Overlength frame, zero hold-off
        b0 = out_beats;
        arm(1, 0);
        send_frame(200, 0, 1'b0);
        wait_idle();
        chk("C_beats", out_beats - b0, 128 + HDR);
        chk("C_err", 32'(error_out), 32'b010);

        // Stall after beat 50, then a clean frame
        b0 = out_beats;
        arm(2, 5);
        send_frame(128, 50, 1'b1);
        chk("D_back_to_holdoff", {30'd0, busy_out, extractor_rst_out}, 32'b11);
        send_frame(128, 0, 1'b0);
        wait_idle();
        chk("D_beats", out_beats - b0, 51 + 128 + 2 * HDR);
        chk("D_err", 32'(error_out), 32'b100);
        chk("D_cnt", 32'(capture_cnt_out), 32'd2);

        // Random sessions with an ignored re-arm while busy
        for (int s = 0; s < 3; s++) begin
            num = $urandom_range(1, 3);
            arm(num, $urandom_range(0, 6));
            for (int f = 0; f < num; f++) begin
                r = $urandom_range(0, 9);
                if (r < 6)      len = 128;
                else if (r < 8) len = $urandom_range(1, 127);
                else            len = $urandom_range(129, 180);
                send_frame(len, 0, 1'b0);
                if (f == 0 && num > 1) begin
                    arm_in = 1'b1;
                    num_captures_in = 5;
                    @(posedge clk_in); #1;
                    arm_in = 1'b0;
                end
            end
            wait_idle();
            chk("E_cnt", 32'(capture_cnt_out), num);
        end

        // Abort mid-frame in continuous mode (arm in the same cycle loses), then re-arm
        arm(0, 4);
        send_frame(20, 0, 1'b0);
        send_frame(128, 30, 1'b0);
        repeat (3) begin
            @(posedge clk_in); #1;
        end
        abort_in = 1'b1;
        arm_in = 1'b1;
        num_captures_in = 1;
        @(posedge clk_in); #1;
        abort_in = 1'b0;
        arm_in = 1'b0;
        chk("F_busy", 32'(busy_out), 32'd0);
        chk("F_m_valid", 32'(m_axis.tvalid), 32'd0);
        chk("F_cnt_held", 32'(capture_cnt_out), 32'd1);
        chk("F_err_held", 32'(error_out), 32'b001);
        @(posedge clk_in); #1;
        chk("F_still_idle", 32'(busy_out), 32'd0);
        arm(1, 2);
        send_frame(128, 0, 1'b0);
        wait_idle();
`ifdef LTS_CAPTURE_HEADER_EN
        chk("F_first_word", first_word, 32'hC5100000);
`else
        chk("F_first_word", first_word, first_data);
`endif
        chk("F_err", 32'(error_out), 32'd0);
        chk("F_cnt", 32'(capture_cnt_out), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog: actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lts_capture_ctrl.md
# lts_capture_ctrl

Capture sequencer between `lts_extractor` and the CSI DMA stream. On an arm request it releases the extractor from reset and forwards each detected LTS frame (LTS_LEN complex samples) through a registered AXI-Stream stage. It enforces frame length, times out stalled frames, inserts a hold-off between captures and stops after a programmed number of captures (or runs continuously).

## Interface
- `LTS_LEN`, 128: samples per capture, i.e. two 64-sample LTS symbols; range 2..65535.
- `TIMEOUT_CYCLES`, 4096: maximum idle cycles between accepted input beats inside a frame.
- `CNT_W`, 16: width of the capture-count and hold-off fields.
- `clk_in` in 1: single clock.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `arm_in` in 1: start pulse; ignored while `busy_out`=1.
- `abort_in` in 1: level, sampled every cycle; highest priority.
- `num_captures_in` in CNT_W: captures per session; 0 = continuous. Latched on arm.
- `holdoff_in` in CNT_W: gap cycles between captures. Latched on arm.
- `extractor_rst_out` out 1: active-high reset to `lts_extractor`.
- `lts_axis_tvalid`, `lts_axis_tlast` in 1; `lts_axis_tdata` in 32 {I[15:0],Q[15:0]}; `lts_axis_tready` out 1.
- `m_axis_tvalid`, `m_axis_tlast` out 1; `m_axis_tdata` out 32; `m_axis_tready` in 1.
- `busy_out` out 1: state ≠ IDLE.
- `done_out` out 1: one-cycle pulse when a finite session completes.
- `capture_cnt_out` out CNT_W: frames completed in the current session.
- `error_out` out 3: sticky {timeout, overlength, short}; cleared when an arm is accepted.

## Operation
- States: IDLE, HOLDOFF, ARMED, HEADER (macro only), STREAM, DRAIN, FLUSH.
- IDLE: `extractor_rst_out`=1. On `arm_in`:
  - latch the configuration;
  - clear `capture_cnt_out` and `error_out`;
  - go to HOLDOFF.
- HOLDOFF: `extractor_rst_out`=1 for max(1, `holdoff_in`) cycles, then go to ARMED.
- ARMED: `extractor_rst_out`=0 and no timeout. The first accepted input beat is forwarded and the state becomes STREAM, or HEADER first when the macro is enabled.
- STREAM: forward beats and count them in `beat_cnt` (the first beat counts as 1).
  - Input `tlast` at `beat_cnt` < LTS_LEN: forward it with `tlast`, set error[0] (short), and the frame ends.
  - `beat_cnt` = LTS_LEN: forward with `tlast` forced to 1. If the input `tlast` is 0, set error[1] (overlength) and go to DRAIN.
  - TIMEOUT_CYCLES consecutive cycles with no accepted input: set error[2], emit one filler beat (tdata=0, tlast=1), and the frame ends.
- DRAIN: `lts_axis_tready`=1. Input beats are discarded until an input `tlast` is accepted, then the frame ends.
- Frame end: `capture_cnt_out` increments.
  - If `num_captures_in`≠0 and the count equals it: go to FLUSH.
  - Otherwise: go to HOLDOFF, which resets the extractor for the next packet.
- FLUSH: wait until the output register is empty, then pulse `done_out` and go to IDLE.
- Output register: `lts_axis_tready` = (state ∈ {ARMED, STREAM}) && (!`m_axis_tvalid` || `m_axis_tready`).
- Abort: `abort_in`=1 in any state forces IDLE at the next edge.
  - `m_axis_tvalid` is cleared.
  - `capture_cnt_out` and `error_out` are held.
  - `done_out` is not pulsed.
- Simultaneous `arm_in` and `abort_in`: abort wins.
- `capture_cnt_out` saturates at 2^CNT_W−1 in continuous mode.

## Timing
- Reset values:
  - `extractor_rst_out`=1;
  - `lts_axis_tready`=0;
  - `m_axis_tvalid`=`m_axis_tlast`=0;
  - `m_axis_tdata`=0;
  - `busy_out`=`done_out`=0;
  - `capture_cnt_out`=0;
  - `error_out`=0.
- Latency: an input beat accepted at edge N appears on `m_axis` after edge N, one cycle.
- Throughput: 1 beat/cycle under continuous `m_axis_tready`.
- AXIS rules:
  - `m_axis_tdata` and `m_axis_tlast` are stable while `m_axis_tvalid`=1 and `m_axis_tready`=0.
  - `m_axis_tvalid` never drops without a handshake, except on abort or reset.
- `busy_out` rises the cycle after an accepted arm.
- `done_out` is asserted the cycle FLUSH exits.
- Timeout counter: resets on every accepted input beat. It fires when its count reaches TIMEOUT_CYCLES; the filler beat waits for a free output slot.

## Configuration
- `LTS_CAPTURE_HEADER_EN` defined:
  - Before each frame's first sample, HEADER emits one word {16'hC510, capture index[15:0]}, where the index is the 0-based capture number.
  - HEADER keeps `lts_axis_tready`=0 until the header is loaded into the output register.
  - The first sample is held upstream and is not counted in `beat_cnt` until it is accepted.
- Not defined: the HEADER state is absent, and frames contain samples only.

## Test plan
- `num_captures_in`=2, `holdoff_in`=10, two clean 128-beat frames with `tlast` on beat 128 -> 256 output beats, `tlast` on beats 128 and 256, `done_out` pulse, `error_out`=0, `extractor_rst_out` high ≥10 cycles between frames.
- Input `tlast` on beat 40 -> output frame of 40 beats with `tlast` on beat 40, error=3'b001, `capture_cnt_out`=1.
- 200-beat input frame -> output `tlast` forced on beat 128, beats 129..200 dropped, error=3'b010.
- Input stalls 4096 cycles after beat 50 -> filler beat 0x00000000 with `tlast`=1, error=3'b100, controller returns to HOLDOFF.
- Random `m_axis_tready` backpressure (50%) -> output data identical to input order, no beat lost or duplicated, data stable while stalled.
- `abort_in` mid-frame, then a new arm -> IDLE next cycle, `m_axis_tvalid`=0, `error_out`=0 and `capture_cnt_out`=0 after the new arm; with the header macro enabled, the first output word is 0xC5100000.
